// File: rtl/uart_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_pkg: register offsets, STATUS bit positions and TX FSM states.  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package uart_pkg;

  localparam logic [1:0] OFF_TXDATA  = 2'd0;
  localparam logic [1:0] OFF_STATUS  = 2'd1;
  localparam logic [1:0] OFF_BAUDDIV = 2'd2;

  localparam int STAT_BUSY   = 0;
  localparam int STAT_FULL   = 1;
  localparam int STAT_EMPTY  = 2;
  localparam int STAT_OVF    = 3;
  localparam int STAT_PARITY = 4;
  localparam int STAT_COUNT  = 8;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } tx_state_e;

endpackage
`default_nettype wire

// File: rtl/uart_tx_mmio_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_tx_mmio_if: CPU data-bus slice seen by the UART register block. |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface uart_tx_mmio_if;
  logic        sel;
  logic        wen;
  logic [3:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (output sel, output wen, output addr, output wdata, input rdata);
  modport slave  (input sel, input wen, input addr, input wdata, output rdata);
endinterface
`default_nettype wire

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_tx_fifo: synchronous byte FIFO with push/pop/full/empty/count.  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module uart_tx_fifo #(
  parameter int DEPTH = 16
) (
  input  wire logic                   clk,
  input  wire logic                   rst,
  input  wire logic                   push,
  input  wire logic                   pop,
  input  wire logic [7:0]             din,
  output logic      [7:0]             dout,
  output logic                        full,
  output logic                        empty,
  output logic      [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  // A pop on the same edge frees the slot, so a push into a full FIFO still lands.
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end
endmodule
`default_nettype wire

// File: rtl/uart_tx_mmio.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_tx_mmio: memory-mapped 8N1 UART transmitter with TX FIFO.       |
// | Define UART_TX_PARITY_EN for 8E1 frames. Rev 1.0                     |
// +----------------------------------------------------------------------+
module uart_tx_mmio
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH  = 16,
  parameter int DIV_W       = 16,
  parameter int DEFAULT_DIV = 868
) (
  input  wire logic       clk,
  input  wire logic       rst,
  uart_tx_mmio_if.slave   bus,
  output logic            txd,
  output logic            irq
);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
`ifdef UART_TX_PARITY_EN
  localparam logic PARITY_EN = 1'b1;
`else
  localparam logic PARITY_EN = 1'b0;
`endif

  tx_state_e        state;
  logic [DIV_W-1:0] baud_div;
  logic [DIV_W-1:0] frame_div;
  logic [DIV_W-1:0] div_cnt;
  logic [DIV_W-1:0] next_div;
  logic [2:0]       bit_idx;
  logic [7:0]       shreg;
  logic             overflow;
`ifdef UART_TX_PARITY_EN
  logic             par_bit;
`endif
  logic [7:0]       fifo_dout;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CNT_W-1:0] fifo_count;
  logic [1:0]       offset;
  logic             wr_txdata;
  logic             wr_status;
  logic             wr_bauddiv;
  logic             busy;
  logic             bit_end;
  logic             launch;
  logic             unused_bits;

  assign offset      = bus.addr[3:2];
  assign wr_txdata   = bus.sel & bus.wen & (offset == OFF_TXDATA);
  assign wr_status   = bus.sel & bus.wen & (offset == OFF_STATUS);
  assign wr_bauddiv  = bus.sel & bus.wen & (offset == OFF_BAUDDIV);
  assign busy        = (state != S_IDLE);
  assign bit_end     = (div_cnt == '0);
  assign launch      = ~fifo_empty & ((state == S_IDLE) | ((state == S_STOP) & bit_end));
  assign next_div    = (baud_div == '0) ? DIV_W'(1) : baud_div;
  assign irq         = fifo_empty & ~busy;
  assign unused_bits = ^{bus.addr[1:0], bus.wdata};

  uart_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (wr_txdata),
    .pop   (launch),
    .din   (bus.wdata[7:0]),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      baud_div <= DIV_W'(DEFAULT_DIV);
      overflow <= 1'b0;
    end else begin
      if (wr_bauddiv) baud_div <= bus.wdata[DIV_W-1:0];
      if (wr_status && bus.wdata[STAT_OVF]) overflow <= 1'b0;
      if (wr_txdata && fifo_full && !launch) overflow <= 1'b1;
    end
  end

  always_comb begin
    bus.rdata = '0;
    case (offset)
      OFF_STATUS: begin
        bus.rdata[STAT_BUSY]            = busy;
        bus.rdata[STAT_FULL]            = fifo_full;
        bus.rdata[STAT_EMPTY]           = fifo_empty;
        bus.rdata[STAT_OVF]             = overflow;
        bus.rdata[STAT_PARITY]          = PARITY_EN;
        bus.rdata[STAT_COUNT +: CNT_W]  = fifo_count;
      end
      OFF_BAUDDIV: bus.rdata[DIV_W-1:0] = baud_div;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      txd       <= 1'b1;
      frame_div <= DIV_W'(DEFAULT_DIV);
      div_cnt   <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
`ifdef UART_TX_PARITY_EN
      par_bit   <= 1'b0;
`endif
    end else if (launch) begin
      // Divider is sampled only here, so mid-frame BAUDDIV writes wait for the next START.
      state     <= S_START;
      txd       <= 1'b0;
      bit_idx   <= '0;
      shreg     <= fifo_dout;
      frame_div <= next_div;
      div_cnt   <= next_div - 1'b1;
`ifdef UART_TX_PARITY_EN
      par_bit   <= ^fifo_dout;
`endif
    end else if (state != S_IDLE) begin
      if (!bit_end) begin
        div_cnt <= div_cnt - 1'b1;
      end else begin
        div_cnt <= frame_div - 1'b1;
        case (state)
          S_START: begin
            state <= S_DATA;
            txd   <= shreg[0];
            shreg <= {1'b0, shreg[7:1]};
          end
          S_DATA: begin
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              state <= S_PARITY;
              txd   <= par_bit;
`else
              state <= S_STOP;
              txd   <= 1'b1;
`endif
            end else begin
              txd   <= shreg[0];
              shreg <= {1'b0, shreg[7:1]};
            end
          end
          S_PARITY: begin
            state <= S_STOP;
            txd   <= 1'b1;
          end
          default: begin
            state <= S_IDLE;
            txd   <= 1'b1;
          end
        endcase
      end
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_uart_tx_mmio.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_uart_tx_mmio: randomized bench with a bit-stream reference model. |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_uart_tx_mmio;
`ifdef UART_TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int DEF_DIV = 868;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic txd;
  logic irq;
  int   checks = 0;
  int   failures = 0;
  bit   exp_txd[$];
  bit   exp_irq[$];
  bit   got_txd[$];
  bit   got_irq[$];

  always #5 clk = ~clk;

  uart_tx_mmio_if bus ();

  uart_tx_mmio #(.FIFO_DEPTH(16), .DIV_W(16), .DEFAULT_DIV(DEF_DIV)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus),
    .txd (txd),
    .irq (irq)
  );

  task automatic idle_bus();
    bus.sel = 1'b0; bus.wen = 1'b0; bus.addr = '0; bus.wdata = '0;
  endtask

  task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
    bus.sel = 1'b1; bus.wen = 1'b1; bus.addr = a; bus.wdata = d;
    @(posedge clk); #1;
    idle_bus();
  endtask

  task automatic bus_read(input logic [3:0] a, output logic [31:0] d);
    bus.sel = 1'b1; bus.wen = 1'b0; bus.addr = a;
    #1 d = bus.rdata;
    idle_bus();
  endtask

  // Expected line: one idle sample, then the sample after the push edge, then frames.
  function automatic void start_stream();
    exp_txd = {1'b1, 1'b1};
    exp_irq = {1'b1, 1'b0};
  endfunction

  function automatic void add_frame(input logic [7:0] b, input int d);
    bit bits[$];
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(b[i]);
    if (PAR != 0) bits.push_back(^b);
    bits.push_back(1'b1);
    foreach (bits[i]) repeat (d) begin exp_txd.push_back(bits[i]); exp_irq.push_back(1'b0); end
  endfunction

  function automatic void end_stream(input int n);
    repeat (n) begin exp_txd.push_back(1'b1); exp_irq.push_back(1'b1); end
  endfunction

  function automatic int first_diff(input bit a[$], input bit b[$]);
    if (a.size() != b.size()) return 0;
    foreach (a[i]) if (a[i] != b[i]) return i;
    return -1;
  endfunction

  task automatic capture(input int n);
    got_txd.delete(); got_irq.delete();
    repeat (n) begin @(negedge clk); got_txd.push_back(txd); got_irq.push_back(irq); end
  endtask

  task automatic test_reset();
    logic [31:0] r;
    logic [31:0] exp_st;
    idle_bus();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    exp_st = 32'h4;
    exp_st[4] = (PAR != 0);
    checks++; if (txd !== 1'b1) begin failures++; $display("FAIL reset_txd got %b want 1", txd); end
    checks++; if (irq !== 1'b1) begin failures++; $display("FAIL reset_irq got %b want 1", irq); end
    bus_read(4'h4, r);
    checks++; if (r !== exp_st) begin failures++; $display("FAIL reset_status got %h want %h", r, exp_st); end
    bus_read(4'h8, r);
    checks++; if (r !== 32'(DEF_DIV)) begin failures++; $display("FAIL reset_bauddiv got %0d want %0d", r, DEF_DIV); end
    bus_write(4'hC, 32'hFFFF_FFFF);
    bus_read(4'hC, r);
    checks++; if (r !== 32'h0) begin failures++; $display("FAIL reg_c_read got %h want 0", r); end
    bus_read(4'h0, r);
    checks++; if (r !== 32'h0) begin failures++; $display("FAIL txdata_read got %h want 0", r); end
  endtask

  task automatic test_single_frame();
    logic [31:0] r;
    logic [31:0] w;
    int idx;
    bus_write(4'h8, 32'd4);
    bus_read(4'h8, r);
    checks++; if (r !== 32'd4) begin failures++; $display("FAIL bauddiv_rw got %0d want 4", r); end
    w = $urandom;
    w[7:0] = 8'h55;
    start_stream(); add_frame(8'h55, 4); end_stream(3);
    fork
      bus_write(4'h0, w);
      capture(exp_txd.size());
    join
    idx = first_diff(got_txd, exp_txd);
    checks++; if (idx != -1) begin failures++; $display("FAIL single_txd sample %0d got %b want %b", idx, got_txd[idx], exp_txd[idx]); end
    idx = first_diff(got_irq, exp_irq);
    checks++; if (idx != -1) begin failures++; $display("FAIL single_irq sample %0d got %b want %b", idx, got_irq[idx], exp_irq[idx]); end
  endtask

  task automatic test_random_frames();
    logic [7:0] b[4];
    int d, n, idx;
    logic [31:0] r;
    for (int it = 0; it < 3; it++) begin
      d = $urandom_range(2, 5);
      n = $urandom_range(2, 4);
      for (int j = 0; j < 4; j++) b[j] = 8'($urandom);
      bus_write(4'h8, 32'(d));
      start_stream();
      for (int j = 0; j < n; j++) add_frame(b[j], d);
      end_stream(3);
      fork
        for (int j = 0; j < n; j++) bus_write(4'h0, {24'($urandom), b[j]});
        capture(exp_txd.size());
      join
      idx = first_diff(got_txd, exp_txd);
      checks++; if (idx != -1) begin failures++; $display("FAIL random_txd it %0d sample %0d got %b want %b", it, idx, got_txd[idx], exp_txd[idx]); end
      idx = first_diff(got_irq, exp_irq);
      checks++; if (idx != -1) begin failures++; $display("FAIL random_irq it %0d sample %0d got %b want %b", it, idx, got_irq[idx], exp_irq[idx]); end
      bus_read(4'h4, r);
      checks++; if (r[2:0] !== 3'b100) begin failures++; $display("FAIL random_drained status %h want empty idle", r); end
    end
  endtask

  task automatic test_overflow_full();
    logic [7:0] b[17];
    logic [7:0] x, y;
    logic [31:0] r;
    int f, idx;
    f = (10 + PAR) * 2;
    for (int j = 0; j < 17; j++) b[j] = 8'($urandom);
    x = 8'($urandom);
    y = 8'($urandom);
    bus_write(4'h8, 32'd2);
    start_stream();
    for (int j = 0; j < 17; j++) add_frame(b[j], 2);
    add_frame(y, 2);
    end_stream(3);
    fork
      begin
        for (int j = 0; j < 17; j++) bus_write(4'h0, {24'h0, b[j]});
        bus_read(4'h4, r);
        checks++; if (r[12:8] !== 5'd16 || r[1] !== 1'b1 || r[3] !== 1'b0) begin
          failures++; $display("FAIL full_status got %h want count 16 full 1 ovf 0", r); end
        bus_write(4'h0, {24'h0, x});
        bus_read(4'h4, r);
        checks++; if (r[3] !== 1'b1 || r[12:8] !== 5'd16) begin
          failures++; $display("FAIL drop_status got %h want ovf 1 count 16", r); end
        bus_write(4'h4, 32'h8);
        bus_read(4'h4, r);
        checks++; if (r[3] !== 1'b0) begin failures++; $display("FAIL ovf_clear got %b want 0", r[3]); end
        repeat (f - 18) begin @(posedge clk); #1; end
        bus_write(4'h0, {24'h0, y});
        bus_read(4'h4, r);
        checks++; if (r[3] !== 1'b0 || r[12:8] !== 5'd16 || r[1] !== 1'b1) begin
          failures++; $display("FAIL push_pop_full got %h want ovf 0 count 16 full 1", r); end
      end
      capture(exp_txd.size());
    join
    idx = first_diff(got_txd, exp_txd);
    checks++; if (idx != -1) begin failures++; $display("FAIL full_txd sample %0d got %b want %b", idx, got_txd[idx], exp_txd[idx]); end
    idx = first_diff(got_irq, exp_irq);
    checks++; if (idx != -1) begin failures++; $display("FAIL full_irq sample %0d got %b want %b", idx, got_irq[idx], exp_irq[idx]); end
  endtask

  task automatic test_baud_change();
    logic [7:0] b0, b1;
    logic [31:0] r;
    int idx;
    b0 = 8'hA5;
    b1 = 8'($urandom);
    bus_write(4'h8, 32'd4);
    start_stream(); add_frame(b0, 4); add_frame(b1, 8); end_stream(3);
    fork
      begin
        bus_write(4'h0, {24'h0, b0});
        bus_write(4'h0, {24'h0, b1});
        bus_write(4'h8, 32'd8);
      end
      capture(exp_txd.size());
    join
    idx = first_diff(got_txd, exp_txd);
    checks++; if (idx != -1) begin failures++; $display("FAIL baud_change_txd sample %0d got %b want %b", idx, got_txd[idx], exp_txd[idx]); end
    bus_read(4'h8, r);
    checks++; if (r !== 32'd8) begin failures++; $display("FAIL baud_change_reg got %0d want 8", r); end
  endtask

  task automatic test_reset_midframe();
    logic [7:0] b;
    logic [31:0] r;
    logic [31:0] exp_st;
    int bad;
    b = 8'hA5;
    bus_write(4'h8, 32'd4);
    bus_write(4'h0, {24'h0, b});
    bus_write(4'h0, 32'h3C);
    repeat (17) @(posedge clk);
    #1;
    checks++; if (txd !== b[3]) begin failures++; $display("FAIL midframe_bit3 got %b want %b", txd, b[3]); end
    bus_read(4'h4, r);
    checks++; if (r[0] !== 1'b1) begin failures++; $display("FAIL midframe_busy got %b want 1", r[0]); end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_st = 32'h4;
    exp_st[4] = (PAR != 0);
    checks++; if (txd !== 1'b1) begin failures++; $display("FAIL abort_txd got %b want 1", txd); end
    bus_read(4'h4, r);
    checks++; if (r !== exp_st) begin failures++; $display("FAIL abort_status got %h want %h", r, exp_st); end
    bus_read(4'h8, r);
    checks++; if (r !== 32'(DEF_DIV)) begin failures++; $display("FAIL abort_bauddiv got %0d want %0d", r, DEF_DIV); end
    capture(30);
    bad = 0;
    foreach (got_txd[i]) if (got_txd[i] !== 1'b1 || got_irq[i] !== 1'b1) bad++;
    checks++; if (bad != 0) begin failures++; $display("FAIL abort_flush got %0d active samples want 0", bad); end
  endtask

  task automatic test_parity();
    logic [31:0] r;
    int idx;
    bus_write(4'h8, 32'd3);
    bus_read(4'h4, r);
    checks++; if (r[4] !== (PAR != 0)) begin failures++; $display("FAIL parity_flag got %b want %0d", r[4], PAR); end
    start_stream(); add_frame(8'h07, 3); end_stream(3);
    fork
      bus_write(4'h0, 32'h07);
      capture(exp_txd.size());
    join
    idx = first_diff(got_txd, exp_txd);
    checks++; if (idx != -1) begin failures++; $display("FAIL parity_txd sample %0d got %b want %b", idx, got_txd[idx], exp_txd[idx]); end
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_single_frame();
    test_random_frames();
    test_overflow_full();
    test_baud_change();
    test_reset_midframe();
    test_parity();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
